lshr_share_arbiter: RTL and testbench



---
 rtl/lshr_share_arbiter.sv | 91 +++++++++
 tb/tb_lshr_share_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lshr_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lshr_share_arbiter
// Brief    : Round-robin arbiter sharing one logical-shift-right datapath
//            between NREQ valid/ready requesters, with a registered result.
// Revision : 1.0 - initial release
// ============================================================================
module lshr_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*WIDTH-1:0] req_amt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id
);

    localparam logic [IDW:0]   c_nreq     = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_last_idx = IDW'(NREQ - 1);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;

    logic             w_can_accept;
    logic             w_found;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW:0]     w_idx;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_sel_amt;
    logic [WIDTH-1:0] w_shift;
    logic             w_xfer;

    assign w_can_accept = !r_valid || resp_ready;

    // Search starts at r_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx[IDW-1:0];
            end
        end
    end

    assign req_ready = (RESETN && w_can_accept && w_found)
                     ? (NREQ'(1) << w_grant_idx) : '0;

    assign w_xfer     = |(req_valid & req_ready);
    assign w_sel_data = req_data[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_amt  = req_amt[int'(w_grant_idx)*WIDTH +: WIDTH];
    // Full-width unsigned amount: anything >= WIDTH shifts every bit out.
    assign w_shift    = w_sel_data >> w_sel_amt;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_shift;
            r_id    <= w_grant_idx;
            r_ptr   <= (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + IDW'(1);
        end else if (r_valid && resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign resp_valid = r_valid;
    assign resp_data  = r_data;
    assign resp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_lshr_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lshr_share_arbiter
// Brief    : Scoreboard bench for lshr_share_arbiter (WIDTH=8, NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lshr_share_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  CLK = 1'b0;
    logic                  RESETN;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_amt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;

    int n_checks = 0;
    int n_pass   = 0;
    logic [IDW+WIDTH-1:0] exp_q[$];

    lshr_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] a);
        req_data[i*WIDTH +: WIDTH] = d;
        req_amt[i*WIDTH +: WIDTH]  = a;
    endtask

    // One clock: drive inputs, check handshake at negedge, queue expected result.
    task automatic cycle(input logic [NREQ-1:0] vld, input logic rr,
                         input logic [NREQ-1:0] exp_ready, input logic push,
                         input logic [WIDTH-1:0] exp_d, input logic [IDW-1:0] exp_id,
                         input logic exp_rv);
        req_valid  = vld;
        resp_ready = rr;
        @(negedge CLK);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (push) exp_q.push_back({exp_id, exp_d});
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN     = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b1;
        @(negedge CLK);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_resp_data", 32'(resp_data), 32'h0);
        check("reset_resp_id", 32'(resp_id), 32'h0);
        @(posedge CLK);
        #1;
        RESETN    = 1'b1;
        req_valid = '0;
    endtask

    task automatic check_hold(input logic [WIDTH-1:0] d, input logic [IDW-1:0] id);
        check("hold_data", 32'(resp_data), 32'(d));
        check("hold_id", 32'(resp_id), 32'(id));
    endtask

    // Monitor: every accepted response is matched against the scoreboard.
    always @(negedge CLK) begin
        if (RESETN === 1'b1 && resp_valid && resp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected: got id=%0d data=0x%0h, none expected", resp_id, resp_data);
            end else begin
                logic [IDW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                if ({resp_id, resp_data} === e) n_pass++;
                else $display("FAIL resp: got id=%0d data=0x%0h expected id=%0d data=0x%0h",
                              resp_id, resp_data, e[IDW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        RESETN = 1'b0; req_valid = '0; resp_ready = 1'b0;
        req_data = '0; req_amt = '0;
        @(posedge CLK); #1;
        do_reset();

        // Single transfer, one-cycle latency.
        set_req(0, 8'hF0, 8'd4);
        cycle(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0, 1'b0);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);

        // Back-to-back round robin from ptr=0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h80, 8'(i));
        cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 8'h80, 2'd0, 1'b0);
        cycle(4'b1111, 1'b1, 4'b0010, 1'b1, 8'h40, 2'd1, 1'b1);
        cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd2, 1'b1);
        cycle(4'b1111, 1'b1, 4'b1000, 1'b1, 8'h10, 2'd3, 1'b1);
        cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 8'h80, 2'd0, 1'b1);

        // Backpressure with result (0x80, id 0) pending, ptr=1.
        set_req(1, 8'hA5, 8'd0);
        set_req(2, 8'hA5, 8'd7);
        for (int s = 0; s < 3; s++) begin
            cycle(4'b0110, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
            @(negedge CLK);
            check_hold(8'h80, 2'd0);
            @(posedge CLK); #1;
        end
        cycle(4'b0110, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd1, 1'b1);
        cycle(4'b0100, 1'b1, 4'b0100, 1'b1, 8'h01, 2'd2, 1'b1);

        // Out-of-range amounts.
        set_req(3, 8'hA5, 8'd8);
        cycle(4'b1000, 1'b1, 4'b1000, 1'b1, 8'h00, 2'd3, 1'b1);
        set_req(0, 8'hA5, 8'hFF);
        cycle(4'b0001, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0, 1'b1);

        // Drain with no new request; ptr stays at 1 so req3 beats req0.
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        check_hold(8'h00, 2'd0);
        set_req(3, 8'hF0, 8'd1);
        cycle(4'b1001, 1'b1, 4'b1000, 1'b1, 8'h78, 2'd3, 1'b0);

        // Reset mid-operation: req1's result is discarded, ptr back to 0.
        cycle(4'b0010, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1);
        do_reset();
        set_req(0, 8'h3C, 8'd2);
        cycle(4'b1001, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0, 1'b0);
        cycle(4'b1001, 1'b1, 4'b1000, 1'b1, 8'h78, 2'd3, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
